// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared bank-state enum and pad-value helper for the top-k input loader.
package topk_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Most negative value when signed, zero when unsigned; callers truncate to their width.
    function automatic logic [63:0] pad_value(input logic sign, input int unsigned width);
        pad_value = sign ? (64'd1 << (width - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/topk_input_loader_if.sv
// rtl/topk_input_loader_if.sv - element input stream and frame output bundle of the loader.
interface topk_input_loader_if #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16
);
    localparam int CW = $clog2(DATALENGTH) + 1;

    logic                 sign_ctrl_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [DATAWIDTH-1:0] in_data_i;
    logic                 in_last_i;

    logic                 frame_valid_o;
    logic                 frame_ready_i;
    logic [DATAWIDTH-1:0] frame_o [DATALENGTH];
    logic                 frame_sign_o;
    logic [CW-1:0]        frame_count_o;

    modport master (
        output sign_ctrl_i, in_valid_i, in_data_i, in_last_i, frame_ready_i,
        input  in_ready_o, frame_valid_o, frame_o, frame_sign_o, frame_count_o
    );

    modport slave (
        input  sign_ctrl_i, in_valid_i, in_data_i, in_last_i, frame_ready_i,
        output in_ready_o, frame_valid_o, frame_o, frame_sign_o, frame_count_o
    );
endinterface

// File: rtl/topk_frame_bank.sv
// rtl/topk_frame_bank.sv - one frame bank: storage, slot counter, state, sign, count.
// Early close and padding exist only when LOADER_PAD_EN is defined.
module topk_frame_bank
    import topk_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    localparam int SW = $clog2(DATALENGTH),
    localparam int CW = SW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_wr_en,
    input  logic [DATAWIDTH-1:0] i_data,
    input  logic                 i_sign,
    input  logic                 i_last,
    input  logic                 i_rd_en,
    output bank_state_e          o_state,
    output logic                 o_close,
    output logic [DATAWIDTH-1:0] o_data [DATALENGTH],
    output logic                 o_sign,
    output logic [CW-1:0]        o_count
);
    bank_state_e          r_state;
    bank_state_e          w_state_nxt;
    logic [SW-1:0]        r_slot;
    logic [DATAWIDTH-1:0] r_data [DATALENGTH];
    logic                 r_sign;
    logic [CW-1:0]        r_count;
    logic                 w_write;
    logic                 w_close;

    assign w_write = i_wr_en && (r_state != BANK_FULL);

`ifdef LOADER_PAD_EN
    logic                 w_sign_eff;
    logic [DATAWIDTH-1:0] w_pad;
    assign w_close    = i_last || (r_slot == SW'(DATALENGTH - 1));
    assign w_sign_eff = (r_state == BANK_EMPTY) ? i_sign : r_sign;
    assign w_pad      = DATAWIDTH'(pad_value(w_sign_eff, DATAWIDTH));
`else
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign w_close       = (r_slot == SW'(DATALENGTH - 1));
`endif

    assign o_close = w_write && w_close;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BANK_EMPTY, BANK_FILLING: if (w_write) w_state_nxt = w_close ? BANK_FULL : BANK_FILLING;
            BANK_FULL:                if (i_rd_en) w_state_nxt = BANK_EMPTY;
            default:                  w_state_nxt = BANK_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= BANK_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot  <= '0;
            r_sign  <= 1'b0;
            r_count <= '0;
            for (int j = 0; j < DATALENGTH; j++) r_data[j] <= '0;
        end else if (w_write) begin
            r_data[r_slot] <= i_data;
            if (r_state == BANK_EMPTY) r_sign <= i_sign;
            r_slot <= w_close ? '0 : r_slot + SW'(1);
`ifdef LOADER_PAD_EN
            if (w_close) begin
                r_count <= CW'(r_slot) + CW'(1);
                for (int j = 0; j < DATALENGTH; j++)
                    if (SW'(j) > r_slot) r_data[j] <= w_pad;
            end
`else
            if (w_close) r_count <= CW'(DATALENGTH);
`endif
        end
    end

    assign o_state = r_state;
    assign o_data  = r_data;
    assign o_sign  = r_sign;
    assign o_count = r_count;
endmodule

// File: rtl/topk_input_loader.sv
// rtl/topk_input_loader.sv - ping-pong loader packing an element stream into frames.
// Define LOADER_PAD_EN to let in_last_i close a frame early with pad fill.
module topk_input_loader
    import topk_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    localparam int CW = $clog2(DATALENGTH) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    topk_input_loader_if.slave bus
);
    bank_state_e          w_state0, w_state1;
    logic                 w_close0, w_close1;
    logic [DATAWIDTH-1:0] w_data0 [DATALENGTH];
    logic [DATAWIDTH-1:0] w_data1 [DATALENGTH];
    logic                 w_sign0, w_sign1;
    logic [CW-1:0]        w_count0, w_count1;
    logic                 r_fill_ptr;
    logic                 r_rd_ptr;
    logic                 w_fill_open;
    logic                 w_accept;
    logic                 w_frame_hs;
    logic                 w_last;

`ifdef LOADER_PAD_EN
    assign w_last = bus.in_last_i;
`else
    logic w_unused_last;
    assign w_unused_last = bus.in_last_i;
    assign w_last        = 1'b0;
`endif

    assign w_fill_open       = (r_fill_ptr ? w_state1 : w_state0) != BANK_FULL;
    assign w_accept          = bus.in_valid_i && w_fill_open;
    assign bus.in_ready_o    = w_fill_open;
    assign bus.frame_valid_o = (r_rd_ptr ? w_state1 : w_state0) == BANK_FULL;
    assign w_frame_hs        = bus.frame_valid_o && bus.frame_ready_i;

    topk_frame_bank #(.DATAWIDTH(DATAWIDTH), .DATALENGTH(DATALENGTH)) u_bank0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_wr_en (w_accept && !r_fill_ptr),
        .i_data  (bus.in_data_i),
        .i_sign  (bus.sign_ctrl_i),
        .i_last  (w_last),
        .i_rd_en (w_frame_hs && !r_rd_ptr),
        .o_state (w_state0),
        .o_close (w_close0),
        .o_data  (w_data0),
        .o_sign  (w_sign0),
        .o_count (w_count0)
    );

    topk_frame_bank #(.DATAWIDTH(DATAWIDTH), .DATALENGTH(DATALENGTH)) u_bank1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_wr_en (w_accept && r_fill_ptr),
        .i_data  (bus.in_data_i),
        .i_sign  (bus.sign_ctrl_i),
        .i_last  (w_last),
        .i_rd_en (w_frame_hs && r_rd_ptr),
        .o_state (w_state1),
        .o_close (w_close1),
        .o_data  (w_data1),
        .o_sign  (w_sign1),
        .o_count (w_count1)
    );

    // Toggling on the closing accept makes the other bank the fill target next cycle, so no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill_ptr <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            if (r_fill_ptr ? w_close1 : w_close0) r_fill_ptr <= ~r_fill_ptr;
            if (w_frame_hs)                       r_rd_ptr   <= ~r_rd_ptr;
        end
    end

    always_comb begin
        for (int i = 0; i < DATALENGTH; i++) bus.frame_o[i] = r_rd_ptr ? w_data1[i] : w_data0[i];
    end

    assign bus.frame_sign_o  = r_rd_ptr ? w_sign1 : w_sign0;
    assign bus.frame_count_o = r_rd_ptr ? w_count1 : w_count0;
endmodule

// File: doc/topk_input_loader.md
TOPK_INPUT_LOADER -- requirements
Module: topk_input_loader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter DATALENGTH, default 16, elements per frame; legal values are powers of two from 4 to 64.
REQ-003 SHALL have one clock and a synchronous, active-high reset, using these ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have the following input-stream ports:
- sign_ctrl_i  in  1  compare mode: 1 = signed, 0 = unsigned.
- in_valid_i  in  1  element offered.
- in_ready_o  out  1  element can be accepted.
- in_data_i  in  DATAWIDTH  element value.
- in_last_i  in  1  element closes the frame early (used only when LOADER_PAD_EN is defined).
REQ-005 SHALL have the following frame-output ports:
- frame_valid_o  out  1  complete frame presented.
- frame_ready_i  in  1  downstream merge network takes the frame.
- frame_o  out  DATAWIDTH x DATALENGTH (unpacked)  frame elements; index 0 is the first accepted element.
- frame_sign_o  out  1  sign_ctrl value captured for this frame.
- frame_count_o  out  $clog2(DATALENGTH)+1  number of real (non-pad) elements.

Function
REQ-006 SHALL accept an element on any cycle where in_valid_i && in_ready_o, and write it to the next slot of the fill bank.
REQ-007 SHALL hold two frame banks (ping-pong); each bank is in one of three states: EMPTY, FILLING, FULL.
REQ-008 SHALL move a bank EMPTY->FILLING on its first accept, FILLING->FULL on the accept that fills slot DATALENGTH-1, and FULL->EMPTY on an output handshake (frame_valid_o && frame_ready_i).
REQ-009 SHALL move the fill pointer to the other bank on the cycle after a bank becomes FULL.
REQ-010 SHALL drive in_ready_o high iff the fill bank is EMPTY or FILLING; in_ready_o is low only when both banks are FULL.
REQ-011 SHALL drive frame_valid_o high iff the read bank is FULL; the read pointer toggles on each output handshake.
REQ-012 SHALL assert frame_valid_o on the cycle after the accept that completes a frame (latency 1) when the read bank was otherwise free.
REQ-013 SHALL sustain one element per cycle with no bubbles whenever frame_ready_i is high at least 1 cycle in every DATALENGTH.
REQ-014 SHALL hold frame_o, frame_sign_o and frame_count_o stable while frame_valid_o && !frame_ready_i.
REQ-015 SHALL capture sign_ctrl_i with the first element of a frame; sign_ctrl_i on later elements of that frame has no effect.
REQ-016 SHALL allow a completing accept and an output handshake in the same cycle, and both take effect.
REQ-017 SHALL ignore in_data_i and in_last_i when the element is not accepted.

Reset
REQ-018 SHALL reset as follows when rst_i is high at a clock edge:
- both banks EMPTY; fill and read pointers to bank 0; slot counter 0;
- in_ready_o=1; frame_valid_o=0; frame_sign_o=0; frame_count_o=0; frame_o all zeros.
REQ-019 SHALL discard any partial or FULL frame when reset is asserted mid-operation; no frame is output after reset release until a new frame completes.

Configuration
REQ-020 SHALL, with LOADER_PAD_EN defined, treat an accepted in_last_i as closing the frame: the bank goes FULL at once, and slots beyond the last one written take the pad value.
REQ-021 SHALL use pad value 1 followed by DATAWIDTH-1 zeros (most negative) when the frame sign is 1, and all zeros when it is 0.
REQ-022 SHALL, with LOADER_PAD_EN defined, set frame_count_o to the number of real elements (1..DATALENGTH); in_last_i on slot DATALENGTH-1 behaves as a normal completion.
REQ-023 SHALL, without LOADER_PAD_EN, ignore in_last_i, include no pad logic, and always drive frame_count_o = DATALENGTH.

Structure
REQ-024 SHALL place the bank-state enum (EMPTY/FILLING/FULL) and a pad-value function of (sign, DATAWIDTH) in shared package topk_pkg.
REQ-025 SHALL implement each bank as one sub-module instance, topk_frame_bank (storage, slot counter, state, sign, count), instantiated twice; steering logic stays in the top.

Verification
REQ-026 SHALL cover single frame: 16 elements 0..15 back-to-back, frame_ready_i=1 -> frame_valid_o one cycle after the 16th accept; frame_o[i]=i; frame_count_o=16.
REQ-027 SHALL cover backpressure: 40 elements continuous, frame_ready_i=0 -> in_ready_o drops after the 32nd accept; raising frame_ready_i gives frames 0..15 then 16..31, and in_ready_o rises on the cycle after the first handshake.
REQ-028 SHALL cover sign capture: sign_ctrl_i=1 on element 0, then 0 for elements 1..15 -> frame_sign_o=1.
REQ-029 SHALL cover pad (with LOADER_PAD_EN): 5 elements, last on the 5th, sign=1, DATAWIDTH=8 -> frame_o[5..15]=8'h80, frame_count_o=5; same case with sign=0 -> pad 8'h00.
REQ-030 SHALL cover reset mid-frame: 7 elements, then rst_i for 1 cycle, then 16 new elements -> only the new frame is output.
REQ-031 SHALL cover simultaneous events: completing accept in the same cycle as a handshake on the other bank -> no lost element, no in_ready_o bubble.
